traceback_unit: RTL and testbench

Survivor-path memory and traceback stage of the Viterbi decoder, sitting directly downstream of the add-compare-select (ACS) unit and gated by the decoder control FSM. It stores the per-cycle survivor decision vectors and the ACS best-state index in a circular window of DEPTH entries. Once the window is full and the control FSM asserts its traceback enable, it traces back through the whole window every cycle and emits one decoded bit per cycle.

---
 rtl/traceback_unit.sv | 83 ++++++++
 tb/tb_traceback_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/traceback_unit.sv
`default_nettype none
// ============================================================================
// traceback_unit : Viterbi survivor-path window with full-depth traceback
// Revision 1.0
// ============================================================================
module traceback_unit #(
    parameter int S     = 2,
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               i_en_m,
    input  logic               i_en_t,
    input  logic [(1<<S)-1:0]  i_dec,
    input  logic [S-1:0]       i_best,
    output logic               o_bit,
    output logic               o_valid,
    output logic               o_full,
    output logic               o_underrun
);

    localparam int N  = 1 << S;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    logic [N-1:0]  dec_mem [DEPTH];
    logic [S-1:0]  best_reg;
    logic [AW-1:0] wr_ptr;
    logic [FW-1:0] fill;
    logic [S-1:0]  trace;
    logic [AW-1:0] rd_idx;

    assign o_full = (fill == FILL_MAX);

    // Walk back from the newest vector; each step shifts the decision bit in as the new LSB.
    always_comb begin
        trace  = best_reg;
        rd_idx = wr_ptr;
        for (int k = 0; k < DEPTH - 1; k++) begin
            rd_idx = wr_ptr - AW'(k + 1);
            trace  = S'({trace, dec_mem[rd_idx][trace]});
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                dec_mem[i] <= '0;
            end
            best_reg   <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
            o_bit      <= 1'b0;
            o_valid    <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (en) begin
                if (i_en_m) begin
                    dec_mem[wr_ptr] <= i_dec;
                    best_reg        <= i_best;
                    wr_ptr          <= wr_ptr + 1'b1;
                    if (fill != FILL_MAX) begin
                        fill <= fill + 1'b1;
                    end
                end
                // Traceback sees the pre-write window; a same-cycle write joins next cycle.
                if (i_en_t) begin
                    if (o_full) begin
                        o_bit   <= trace[S-1];
                        o_valid <= 1'b1;
                    end else begin
                        o_underrun <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_traceback_unit.sv
`default_nettype none
// Testbench for traceback_unit: queue-based reference model with scoreboard monitor.
module tb_traceback_unit;

    localparam int S     = 2;
    localparam int DEPTH = 8;
    localparam int N     = 1 << S;

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic         en   = 1'b0;
    logic         en_m = 1'b0;
    logic         en_t = 1'b0;
    logic [N-1:0] dec  = '0;
    logic [S-1:0] best = '0;
    logic         o_bit, o_valid, o_full, o_underrun;

    int compared   = 0;
    int mismatched = 0;

    traceback_unit #(.S(S), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .i_en_m     (en_m),
        .i_en_t     (en_t),
        .i_dec      (dec),
        .i_best     (best),
        .o_bit      (o_bit),
        .o_valid    (o_valid),
        .o_full     (o_full),
        .o_underrun (o_underrun)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [N-1:0] hist[$];
    logic         exp_q[$];
    int           best_m  = 0;
    int           writes  = 0;
    logic         under_m = 1'b0;

    function automatic logic ref_trace();
        int st = best_m;
        for (int k = 0; k < DEPTH - 1; k++) begin
            logic [N-1:0] v = hist[DEPTH - 1 - k];
            st = ((st << 1) | int'(v[st])) % N;
        end
        return logic'((st >> (S - 1)) & 1);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist.delete();
            exp_q.delete();
            best_m  = 0;
            writes  = 0;
            under_m = 1'b0;
        end else if (en) begin
            if (en_t) begin
                if (writes >= DEPTH) exp_q.push_back(ref_trace());
                else under_m = 1'b1;
            end
            if (en_m) begin
                hist.push_back(dec);
                if (hist.size() > DEPTH) void'(hist.pop_front());
                best_m = int'(best);
                writes++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        check("o_full", 32'(o_full), 32'(writes >= DEPTH));
        check("o_underrun", 32'(o_underrun), 32'(under_m));
        if (o_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(o_valid), 32'd0);
            end else begin
                logic e;
                e = exp_q.pop_front();
                check("o_bit", 32'(o_bit), 32'(e));
            end
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            check("missing_valid", 32'(o_valid), 32'd1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic e, input logic m, input logic t,
                         input logic [N-1:0] d, input logic [S-1:0] b);
        en = e; en_m = m; en_t = t; dec = d; best = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 0; en_m = 0; en_t = 0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic rand_drive(input logic e, input logic m, input logic t);
        drive(e, m, t, N'($urandom_range(0, N - 1)), S'($urandom_range(0, N - 1)));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b0;
        #2;
        check("reset_o_bit", 32'(o_bit), 32'd0);
        check("reset_o_valid", 32'(o_valid), 32'd0);
        check("reset_o_full", 32'(o_full), 32'd0);
        check("reset_o_underrun", 32'(o_underrun), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // All-zero path
        for (int i = 0; i < DEPTH; i++) drive(1, 1, 0, '0, '0);
        check("full_after_depth_writes", 32'(o_full), 32'd1);
        for (int i = 0; i < 6; i++) drive(1, 1, 1, '0, '0);

        // All-ones path, traceback rises after the 8th write
        do_reset();
        for (int i = 0; i < 12; i++) drive(1, 1, (i >= DEPTH), '1, S'(N - 1));
        // Async reset while o_valid is high
        en = 0; en_m = 0; en_t = 0;
        check("pre_reset_valid", 32'(o_valid), 32'd1);
        check("pre_reset_bit", 32'(o_bit), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_o_valid", 32'(o_valid), 32'd0);
        check("async_o_bit", 32'(o_bit), 32'd0);
        check("async_o_full", 32'(o_full), 32'd0);
        check("async_o_underrun", 32'(o_underrun), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        // First valid only after DEPTH fresh writes (earlier requests flag underrun)
        for (int i = 0; i < 12; i++) rand_drive(1, 1, 1);

        // Underrun after 5 writes; flag stays after window fills
        do_reset();
        for (int i = 0; i < 5; i++) rand_drive(1, 1, 0);
        for (int i = 0; i < 10; i++) rand_drive(1, 1, 1);
        check("underrun_sticky", 32'(o_underrun), 32'd1);

        // Stall mid-stream
        do_reset();
        for (int i = 0; i < 20; i++) rand_drive((i < 12 || i > 14), 1, (i >= DEPTH));

        // Wrap-around: 40 random writes with both enables high
        do_reset();
        for (int i = 0; i < 40; i++) rand_drive(1, 1, 1);

        // Random enables
        do_reset();
        for (int i = 0; i < 300; i++)
            rand_drive(logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 1)),
                       logic'($urandom_range(0, 1)));

        drive(1, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
